eth_tx_scheduler: RTL and testbench
===================================

ETH_TX_SCHEDULER -- requirements
Module: eth_tx_scheduler

Interface
REQ-001 Parameter LINES_PER_FRAME, default 480, camera lines per frame; line_num wraps at LINES_PER_FRAME-1.
REQ-002 Parameter IFG_CYCLES, default 24, idle clk cycles enforced after each frame's FCS completes.
REQ-003 Parameter TIMEOUT_CYCLES, default 4096, handshake watchdog limit; used only with ETH_TX_TIMEOUT_EN.
REQ-004 clk  in  1  single system clock; all logic on posedge clk.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 line_done  in  1  one-cycle pulse: capture side finished writing a line buffer bank.
REQ-007 wr_bank  in  1  bank index (0/1) qualified by line_done.
REQ-008 frame_start  in  1  one-cycle pulse at camera VSYNC.
REQ-009 eth_finish  in  1  one-cycle pulse from frame builder: header+payload sent.
REQ-010 fcs_finish  in  1  one-cycle pulse from CRC block: FCS sent.
REQ-011 eth_start  out  1  one-cycle pulse starting the frame builder.
REQ-012 fcs_start  out  1  one-cycle pulse starting FCS emission.
REQ-013 tx_bank  out  1  bank the frame builder reads; stable from eth_start until release.
REQ-014 line_num  out  10  line index carried in the frame header; stable during a transfer.
REQ-015 bank_full  out  2  per-bank pending/in-use flags; capture writes bank b only if bank_full[b]==0.
REQ-016 overflow  out  1  sticky: line_done arrived for an already-full bank.
REQ-017 timeout  out  1  sticky: handshake watchdog expired.
REQ-018 FSM_STATE  out  3  current state encoding, for debug.

Function
REQ-019 States (encoding): IDLE=0, START=1, ETH_WAIT=2, FCS=3, FCS_WAIT=4, GAP=5.
REQ-020 IDLE: if bank_full[rd_ptr]==1, next START; else stay.
REQ-021 START: eth_start=1 for exactly this cycle, tx_bank=rd_ptr; next ETH_WAIT.
REQ-022 ETH_WAIT: on eth_finish next FCS; else stay.
REQ-023 FCS: fcs_start=1 for exactly this cycle; next FCS_WAIT.
REQ-024 FCS_WAIT: on fcs_finish, clear bank_full[tx_bank], toggle rd_ptr, advance line_num, load gap counter; next GAP.
REQ-025 GAP: count IFG_CYCLES cycles, then IDLE; minimum START-to-START spacing is therefore 4+IFG_CYCLES cycles plus handshake latency.
REQ-026 line_num advance: +1, wrapping LINES_PER_FRAME-1 -> 0.
REQ-027 line_done sets bank_full[wr_bank]; if already set, the line is dropped, overflow set, state unaffected.
REQ-028 line_done on the bank being released in the same cycle: release first, then set; bank ends full, no overflow.
REQ-029 frame_start in IDLE: line_num=0 and rd_ptr=0 next cycle; in any other state: latched, applied on the GAP->IDLE transition, overriding the REQ-026 increment.
REQ-030 eth_finish/fcs_finish outside their wait states are ignored.

Reset
REQ-031 While reset==0: state IDLE, eth_start=0, fcs_start=0, tx_bank=0, rd_ptr=0, line_num=0, bank_full=2'b00, overflow=0, timeout=0, gap/watchdog counters 0, frame_start latch cleared.
REQ-032 Reset asserted mid-transfer aborts it immediately; no pulse is emitted during or on the first cycle after reset release.

Configuration
REQ-033 Macro ETH_TX_TIMEOUT_EN defined: watchdog counts cycles in ETH_WAIT and FCS_WAIT; reaching TIMEOUT_CYCLES without the expected finish sets timeout, performs REQ-024 release actions, and enters GAP.
REQ-034 Macro undefined: no watchdog logic, wait states hold indefinitely, timeout tied to 0.

Structure
REQ-035 Shared package holds state encodings, 10-bit line-number width, and default parameter constants.
REQ-036 One sub-module, eth_tx_bank_tracker: bank_full flags, rd_ptr, overflow, REQ-027/028 priority.

Verification
REQ-037 line_done wr_bank=0; finish pulses after 10 cycles each -> one eth_start, tx_bank=0, line_num=0, bank_full returns 00, next line_num=1.
REQ-038 Two line_done (banks 0, 1) back to back -> two transfers, tx_bank 0 then 1, START-to-START gap >= 4+24 cycles.
REQ-039 Second line_done on bank 0 while full -> overflow=1, exactly one transfer, bank_full[1] unchanged.
REQ-040 Force line_num 479 then complete transfer -> line_num 0; frame_start during ETH_WAIT -> line_num 0 after GAP, not incremented.
REQ-041 ETH_TX_TIMEOUT_EN defined, eth_finish withheld -> timeout=1 after 4096 cycles, bank released, GAP then IDLE; undefined -> stays in ETH_WAIT, timeout=0.
REQ-042 reset low during FCS_WAIT -> all outputs at REQ-031 values; no eth_start/fcs_start pulse around release.

Source files
------------

// File: rtl/eth_tx_scheduler_pkg.sv
// Shared definitions for the line-buffer Ethernet transmit scheduler:
// FSM state encodings, line-number width and default parameter values.
package eth_tx_scheduler_pkg;

    localparam int LINE_W              = 10;
    localparam int DEF_LINES_PER_FRAME = 480;
    localparam int DEF_IFG_CYCLES      = 24;
    localparam int DEF_TIMEOUT_CYCLES  = 4096;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_ETH_WAIT = 3'd2,
        ST_FCS      = 3'd3,
        ST_FCS_WAIT = 3'd4,
        ST_GAP      = 3'd5
    } state_t;

    // Next line index. Anything at or past the last line wraps to zero.
    function automatic logic [LINE_W-1:0] next_line(input logic [LINE_W-1:0] cur,
                                                    input int lines);
        if (cur >= LINE_W'(lines - 1)) begin
            return '0;
        end
        return cur + 1'b1;
    endfunction

endpackage

// File: rtl/eth_tx_bank_tracker.sv
// Ping-pong line buffer bookkeeping: per-bank full flags, the read pointer
// and the sticky overflow flag for lines arriving on an occupied bank.
module eth_tx_bank_tracker (
    input  logic       clk,
    input  logic       reset,
    input  logic       line_done,
    input  logic       wr_bank,
    input  logic       release_en,
    input  logic       release_bank,
    input  logic       ptr_clear,
    output logic [1:0] bank_full,
    output logic       rd_ptr,
    output logic       overflow
);

    logic [1:0] set_mask;
    logic [1:0] clr_mask;
    logic       drop;

    // A release in the same cycle frees the bank before the new line claims it.
    always_comb begin
        set_mask = 2'b00;
        clr_mask = 2'b00;
        if (release_en) begin
            clr_mask[release_bank] = 1'b1;
        end
        drop = line_done && bank_full[wr_bank] && !clr_mask[wr_bank];
        if (line_done && !drop) begin
            set_mask[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_full <= 2'b00;
            rd_ptr    <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            bank_full <= (bank_full & ~clr_mask) | set_mask;
            if (drop) begin
                overflow <= 1'b1;
            end
            if (ptr_clear) begin
                rd_ptr <= 1'b0;
            end else if (release_en) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

endmodule

// File: rtl/eth_tx_scheduler.sv
// Sequences frame builder and FCS emission for each filled line bank, then
// enforces the inter-frame gap. Optional watchdog: define ETH_TX_TIMEOUT_EN.
module eth_tx_scheduler
    import eth_tx_scheduler_pkg::*;
#(
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int IFG_CYCLES      = DEF_IFG_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              line_done,
    input  logic              wr_bank,
    input  logic              frame_start,
    input  logic              eth_finish,
    input  logic              fcs_finish,
    output logic              eth_start,
    output logic              fcs_start,
    output logic              tx_bank,
    output logic [LINE_W-1:0] line_num,
    output logic [1:0]        bank_full,
    output logic              overflow,
    output logic              timeout,
    output logic [2:0]        FSM_STATE
);

    localparam int GAP_W = $clog2(IFG_CYCLES + 1) + 1;

    state_t           state;
    logic             rd_ptr;
    logic             release_en;
    logic             ptr_clear;
    logic             wd_expire;
    logic             frame_pend;
    logic             gap_done;
    logic [GAP_W-1:0] gap_cnt;

    assign FSM_STATE = state;
    assign gap_done  = (gap_cnt <= GAP_W'(1));

    // Bank release happens on FCS completion or on a watchdog expiry.
    assign release_en = (state == ST_FCS_WAIT && fcs_finish) || wd_expire;

    // rd_ptr returns to bank 0 on a frame restart, immediate in IDLE or deferred to GAP exit.
    assign ptr_clear = (state == ST_IDLE && frame_start) ||
                       (state == ST_GAP && gap_done && (frame_pend || frame_start));

    eth_tx_bank_tracker u_bank_tracker (
        .clk          (clk),
        .reset        (reset),
        .line_done    (line_done),
        .wr_bank      (wr_bank),
        .release_en   (release_en),
        .release_bank (tx_bank),
        .ptr_clear    (ptr_clear),
        .bank_full    (bank_full),
        .rd_ptr       (rd_ptr),
        .overflow     (overflow)
    );

`ifdef ETH_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1) + 1;

    logic [WD_W-1:0] wd_cnt;
    logic            in_wait;
    logic            wait_done;

    assign in_wait   = (state == ST_ETH_WAIT) || (state == ST_FCS_WAIT);
    assign wait_done = (state == ST_ETH_WAIT && eth_finish) ||
                       (state == ST_FCS_WAIT && fcs_finish);
    assign wd_expire = in_wait && !wait_done && (wd_cnt >= WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (in_wait && !wait_done && !wd_expire) begin
                wd_cnt <= wd_cnt + 1'b1;
            end else begin
                wd_cnt <= '0;
            end
            if (wd_expire) begin
                timeout <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign wd_expire          = 1'b0;
    assign timeout            = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            eth_start  <= 1'b0;
            fcs_start  <= 1'b0;
            tx_bank    <= 1'b0;
            line_num   <= '0;
            gap_cnt    <= '0;
            frame_pend <= 1'b0;
        end else begin
            eth_start <= 1'b0;
            fcs_start <= 1'b0;
            if (frame_start && state != ST_IDLE) begin
                frame_pend <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    // A frame restart takes this cycle; the bank check resumes next cycle.
                    if (frame_start) begin
                        line_num <= '0;
                    end else if (bank_full[rd_ptr]) begin
                        state     <= ST_START;
                        eth_start <= 1'b1;
                        tx_bank   <= rd_ptr;
                    end
                end
                ST_START: begin
                    state <= ST_ETH_WAIT;
                end
                ST_ETH_WAIT: begin
                    if (eth_finish) begin
                        state     <= ST_FCS;
                        fcs_start <= 1'b1;
                    end else if (release_en) begin
                        state    <= ST_GAP;
                        line_num <= next_line(line_num, LINES_PER_FRAME);
                        gap_cnt  <= GAP_W'(IFG_CYCLES);
                    end
                end
                ST_FCS: begin
                    state <= ST_FCS_WAIT;
                end
                ST_FCS_WAIT: begin
                    if (release_en) begin
                        state    <= ST_GAP;
                        line_num <= next_line(line_num, LINES_PER_FRAME);
                        gap_cnt  <= GAP_W'(IFG_CYCLES);
                    end
                end
                ST_GAP: begin
                    if (gap_done) begin
                        state <= ST_IDLE;
                        if (frame_pend || frame_start) begin
                            line_num   <= '0;
                            frame_pend <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Self-checking bench for eth_tx_scheduler; expected banks are queued when
// line_done is driven and compared at each eth_start. Honors ETH_TX_TIMEOUT_EN.
module tb_eth_tx_scheduler;

    localparam int LINES = 480;
    localparam int IFG   = 24;
    localparam int TMO   = 4096;

    logic       clk         = 1'b0;
    logic       reset       = 1'b0;
    logic       line_done   = 1'b0;
    logic       wr_bank     = 1'b0;
    logic       frame_start = 1'b0;
    logic       eth_finish  = 1'b0;
    logic       fcs_finish  = 1'b0;
    logic       eth_start;
    logic       fcs_start;
    logic       tx_bank;
    logic [9:0] line_num;
    logic [1:0] bank_full;
    logic       overflow;
    logic       timeout;
    logic [2:0] FSM_STATE;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_start  = -1;
    int start_gap   = 0;

    logic [0:0] exp_q[$];
    logic [1:0] mdl_full = 2'b00;
    logic       mdl_ovf  = 1'b0;
    logic [9:0] exp_line = 10'd0;
    logic       fs_pend  = 1'b0;

    eth_tx_scheduler #(
        .LINES_PER_FRAME (LINES),
        .IFG_CYCLES      (IFG),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .line_done   (line_done),
        .wr_bank     (wr_bank),
        .frame_start (frame_start),
        .eth_finish  (eth_finish),
        .fcs_finish  (fcs_finish),
        .eth_start   (eth_start),
        .fcs_start   (fcs_start),
        .tx_bank     (tx_bank),
        .line_num    (line_num),
        .bank_full   (bank_full),
        .overflow    (overflow),
        .timeout     (timeout),
        .FSM_STATE   (FSM_STATE)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Driver and wait tasks
    task automatic reset_dut();
        reset       = 1'b0;
        line_done   = 1'b0;
        wr_bank     = 1'b0;
        frame_start = 1'b0;
        eth_finish  = 1'b0;
        fcs_finish  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        mdl_full   = 2'b00;
        mdl_ovf    = 1'b0;
        exp_line   = 10'd0;
        fs_pend    = 1'b0;
        last_start = -1;
    endtask

    task automatic pulse_line_done(input logic bank);
        line_done = 1'b1;
        wr_bank   = bank;
        if (mdl_full[bank]) begin
            mdl_ovf = 1'b1;
        end else begin
            mdl_full[bank] = 1'b1;
            exp_q.push_back(bank);
        end
        @(negedge clk);
        line_done = 1'b0;
    endtask

    task automatic wait_eth_start(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (eth_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (FSM_STATE === st) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // One full transfer: check start against the scoreboard, answer the
    // handshakes, update the model at release and check the idle state after GAP.
    task automatic do_transfer(input int eth_dly, input int fcs_dly,
                               input bit fs_in_wait, input bit ld_on_release);
        bit         seen;
        logic [0:0] bank;
        wait_eth_start(200, seen);
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL eth_start_wait: eth_start=%0b after 200 cycles, required 1", eth_start);
            return;
        end
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_eth_start: tx_bank=%0d, required no transfer", tx_bank);
            return;
        end
        bank = exp_q.pop_front();
        vectors++;
        if (tx_bank !== bank) begin
            miscompares++;
            $display("FAIL tx_bank: got %0d, required %0d", tx_bank, bank);
        end
        vectors++;
        if (line_num !== exp_line) begin
            miscompares++;
            $display("FAIL line_num_at_start: got %0d, required %0d", line_num, exp_line);
        end
        start_gap  = (last_start < 0) ? 0 : cyc - last_start;
        last_start = cyc;
        @(negedge clk);
        if (fs_in_wait) begin
            frame_start = 1'b1;
            fs_pend     = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
        end
        repeat (eth_dly) @(negedge clk);
        eth_finish = 1'b1;
        @(negedge clk);
        eth_finish = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (fcs_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL fcs_start_wait: fcs_start=%0b, required 1", fcs_start);
            return;
        end
        @(negedge clk);
        repeat (fcs_dly) @(negedge clk);
        fcs_finish     = 1'b1;
        mdl_full[bank] = 1'b0;
        if (ld_on_release) begin
            line_done      = 1'b1;
            wr_bank        = bank;
            mdl_full[bank] = 1'b1;
            exp_q.push_back(bank);
        end
        exp_line = (exp_line == 10'(LINES - 1)) ? 10'd0 : exp_line + 10'd1;
        @(negedge clk);
        fcs_finish = 1'b0;
        line_done  = 1'b0;
        wait_state(3'd0, IFG + 10, seen);
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL idle_after_gap: FSM_STATE=%0d, required 0", FSM_STATE);
        end
        if (fs_pend) begin
            exp_line = 10'd0;
            fs_pend  = 1'b0;
        end
        vectors++;
        if (line_num !== exp_line) begin
            miscompares++;
            $display("FAIL line_num_after: got %0d, required %0d", line_num, exp_line);
        end
        vectors++;
        if (bank_full !== mdl_full) begin
            miscompares++;
            $display("FAIL bank_full_after: got %b, required %b", bank_full, mdl_full);
        end
        vectors++;
        if (overflow !== mdl_ovf) begin
            miscompares++;
            $display("FAIL overflow_after: got %b, required %b", overflow, mdl_ovf);
        end
    endtask

    // Scenarios
    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({FSM_STATE, eth_start, fcs_start, tx_bank, line_num, bank_full, overflow, timeout} !== 20'd0) begin
            miscompares++;
            $display("FAIL reset_values: state=%0d line=%0d full=%b ovf=%b tmo=%b, required all 0",
                     FSM_STATE, line_num, bank_full, overflow, timeout);
        end
        line_done = 1'b1;
        wr_bank   = 1'b1;
        @(negedge clk);
        line_done = 1'b0;
        vectors++;
        if (bank_full !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ignores_line_done: bank_full=%b, required 00", bank_full);
        end
        reset_dut();
    endtask

    task automatic test_single_line();
        bit seen;
        reset_dut();
        pulse_line_done(1'b0);
        do_transfer(10, 10, 1'b0, 1'b0);
        wait_eth_start(40, seen);
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL single_extra_start: eth_start=1, required 0");
        end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        pulse_line_done(1'b0);
        pulse_line_done(1'b1);
        vectors++;
        if (bank_full !== 2'b11) begin
            miscompares++;
            $display("FAIL b2b_bank_full: got %b, required 11", bank_full);
        end
        do_transfer(2, 2, 1'b0, 1'b0);
        do_transfer(3, 1, 1'b0, 1'b0);
        vectors++;
        if (start_gap < 4 + IFG) begin
            miscompares++;
            $display("FAIL b2b_start_spacing: got %0d cycles, required >= %0d", start_gap, 4 + IFG);
        end
    endtask

    task automatic test_overflow();
        bit seen;
        reset_dut();
        pulse_line_done(1'b0);
        pulse_line_done(1'b0);
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_set: got %b, required 1", overflow);
        end
        vectors++;
        if (bank_full !== 2'b01) begin
            miscompares++;
            $display("FAIL overflow_bank_full: got %b, required 01", bank_full);
        end
        do_transfer(1, 1, 1'b0, 1'b0);
        wait_eth_start(60, seen);
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL overflow_extra_start: eth_start=1, required 0");
        end
    endtask

    task automatic test_line_wrap();
        logic b;
        reset_dut();
        for (int i = 0; i < LINES; i++) begin
            b = i[0];
            pulse_line_done(b);
            do_transfer(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'b0, 1'b0);
        end
        vectors++;
        if (line_num !== 10'd0) begin
            miscompares++;
            $display("FAIL line_wrap: got %0d, required 0", line_num);
        end
    endtask

    task automatic test_frame_start();
        reset_dut();
        pulse_line_done(1'b0);
        do_transfer(1, 1, 1'b0, 1'b0);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        exp_line    = 10'd0;
        vectors++;
        if (line_num !== exp_line) begin
            miscompares++;
            $display("FAIL frame_start_idle: line_num=%0d, required %0d", line_num, exp_line);
        end
        pulse_line_done(1'b0);
        do_transfer(2, 1, 1'b0, 1'b0);
        pulse_line_done(1'b1);
        do_transfer(3, 2, 1'b1, 1'b0);
        pulse_line_done(1'b0);
        do_transfer(1, 1, 1'b0, 1'b0);
    endtask

    task automatic test_same_cycle_release();
        reset_dut();
        pulse_line_done(1'b0);
        pulse_line_done(1'b1);
        do_transfer(1, 1, 1'b0, 1'b1);
        do_transfer(1, 1, 1'b0, 1'b0);
        do_transfer(1, 1, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        bit         seen;
        logic [0:0] bank;
        reset_dut();
        pulse_line_done(1'b0);
        wait_eth_start(20, seen);
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL timeout_start: eth_start=%0b, required 1", eth_start);
            return;
        end
        bank = exp_q.pop_front();
        vectors++;
        if (tx_bank !== bank) begin
            miscompares++;
            $display("FAIL timeout_tx_bank: got %0d, required %0d", tx_bank, bank);
        end
        repeat (TMO - 6) @(negedge clk);
        vectors++;
        if (FSM_STATE !== 3'd2 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early: state=%0d timeout=%b, required 2/0", FSM_STATE, timeout);
        end
        repeat (10) @(negedge clk);
`ifdef ETH_TX_TIMEOUT_EN
        vectors++;
        if (timeout !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_flag: got %b, required 1", timeout);
        end
        vectors++;
        if (bank_full !== 2'b00) begin
            miscompares++;
            $display("FAIL timeout_release: bank_full=%b, required 00", bank_full);
        end
        wait_state(3'd0, IFG + 10, seen);
        vectors++;
        if (!seen || line_num !== 10'd1) begin
            miscompares++;
            $display("FAIL timeout_to_idle: state=%0d line=%0d, required 0/1", FSM_STATE, line_num);
        end
`else
        vectors++;
        if (FSM_STATE !== 3'd2 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL no_watchdog_hold: state=%0d timeout=%b, required 2/0", FSM_STATE, timeout);
        end
        vectors++;
        if (bank_full !== 2'b01) begin
            miscompares++;
            $display("FAIL no_watchdog_bank: bank_full=%b, required 01", bank_full);
        end
`endif
    endtask

    task automatic test_reset_mid();
        bit         seen;
        bit         pulse_seen;
        logic [0:0] bank;
        reset_dut();
        pulse_line_done(1'b0);
        pulse_line_done(1'b1);
        do_transfer(2, 2, 1'b0, 1'b0);
        wait_eth_start(20, seen);
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL reset_mid_start: eth_start=%0b, required 1", eth_start);
            return;
        end
        bank = exp_q.pop_front();
        vectors++;
        if (tx_bank !== bank) begin
            miscompares++;
            $display("FAIL reset_mid_tx_bank: got %0d, required %0d", tx_bank, bank);
        end
        @(negedge clk);
        eth_finish = 1'b1;
        @(negedge clk);
        eth_finish = 1'b0;
        @(negedge clk);
        vectors++;
        if (FSM_STATE !== 3'd4) begin
            miscompares++;
            $display("FAIL reset_mid_in_fcs_wait: state=%0d, required 4", FSM_STATE);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({FSM_STATE, eth_start, fcs_start, tx_bank, line_num, bank_full, overflow, timeout} !== 20'd0) begin
            miscompares++;
            $display("FAIL reset_mid_values: state=%0d bank=%0d line=%0d full=%b, required all 0",
                     FSM_STATE, tx_bank, line_num, bank_full);
        end
        pulse_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (eth_start !== 1'b0 || fcs_start !== 1'b0) pulse_seen = 1'b1;
        end
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (eth_start !== 1'b0 || fcs_start !== 1'b0) pulse_seen = 1'b1;
        end
        vectors++;
        if (pulse_seen) begin
            miscompares++;
            $display("FAIL reset_mid_pulse: start pulse seen around reset release, required none");
        end
        exp_q.delete();
        mdl_full = 2'b00;
        mdl_ovf  = 1'b0;
        exp_line = 10'd0;
    endtask

    // Sequence and report
    initial begin
        test_reset();
        test_single_line();
        test_back_to_back();
        test_overflow();
        test_line_wrap();
        test_frame_start();
        test_same_cycle_release();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        miscompares++;
        $display("FAIL global_time_limit: simulation still running at 5 ms, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1);
    end

endmodule
